// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

   typedef enum logic {ST_CLEAR, ST_RUN} arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the other port after any grant.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       enable,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11) begin
            grant = (ptr_q == PORT0) ? 2'b01 : 2'b10;
         end else begin
            grant = valid;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant[0]) begin
         ptr_d = PORT1;
      end else if (grant[1]) begin
         ptr_d = PORT0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PORT0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple-dual-port RAM between two requesters with round-robin arbitration.
// Define RAM_CLEAR_EN to zero the whole RAM after every reset before granting any access.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_valid,
   output logic                  p0_ready,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_valid,
   output logic                  p1_ready,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic [ADDR_WIDTH-1:0] ram_read_address,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic                  ram_write,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   arb_state_e            state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic [1:0]            grant;
   logic                  arb_en;
   logic                  sel;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rd_grant;
   logic                  wr_grant;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  rd_pend_q;
   logic                  rd_owner_q;

`ifdef RAM_CLEAR_EN
   arb_state_e            state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Counter wraps to 0 on the same edge that leaves CLEAR.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
         if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
   end
`else
   assign state_q   = ST_RUN;
   assign clr_cnt_q = '0;
`endif

   // Gating with rst_n keeps ready low for the whole reset pulse, not just after an edge.
   assign arb_en = rst_n && (state_q == ST_RUN);

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({p1_valid, p0_valid}),
      .enable (arb_en),
      .grant  (grant)
   );

   assign p0_ready  = grant[0];
   assign p1_ready  = grant[1];
   assign sel       = grant[1];
   assign req_we    = sel ? p1_we    : p0_we;
   assign req_addr  = sel ? p1_addr  : p0_addr;
   assign req_wdata = sel ? p1_wdata : p0_wdata;
   assign rd_grant  = (|grant) && !req_we;
   assign wr_grant  = (|grant) && req_we;

   always_comb begin
      ram_write         = 1'b0;
      ram_write_address = '0;
      ram_din           = '0;
      ram_read_address  = rd_addr_q;
      if (rst_n && (state_q == ST_CLEAR)) begin
         ram_write         = 1'b1;
         ram_write_address = clr_cnt_q;
      end else if (wr_grant) begin
         ram_write         = 1'b1;
         ram_write_address = req_addr;
         ram_din           = req_wdata;
      end
      if (rd_grant) begin
         ram_read_address = req_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_q  <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= PORT0;
      end else begin
         rd_pend_q <= rd_grant;
         if (rd_grant) begin
            rd_addr_q  <= req_addr;
            rd_owner_q <= sel;
         end
      end
   end

   assign p0_rsp_valid = rd_pend_q && (rd_owner_q == PORT0);
   assign p1_rsp_valid = rd_pend_q && (rd_owner_q == PORT1);
   assign p0_rdata     = ram_dout;
   assign p1_rdata     = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural simple-dual-port RAM (registered read).
// Build with RAM_CLEAR_EN defined to exercise the post-reset clear sequence.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_valid, p0_we, p1_valid, p1_we;
   logic [7:0]  p0_addr, p1_addr;
   logic [15:0] p0_wdata, p1_wdata;
   logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
   logic [15:0] p0_rdata, p1_rdata;
   logic [7:0]  ram_read_address, ram_write_address;
   logic        ram_write;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mem [256];
   logic        loaded = 1'b0;

   always #5 clk = ~clk;

   // Preload stands in for the $readmem image: word i = 0xA500 | i.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
         loaded <= 1'b1;
      end else if (ram_write) begin
         mem[ram_write_address] <= ram_din;
      end
      ram_dout <= mem[ram_read_address];
   end

   ram_port_arbiter #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .p0_valid          (p0_valid),
      .p0_ready          (p0_ready),
      .p0_we             (p0_we),
      .p0_addr           (p0_addr),
      .p0_wdata          (p0_wdata),
      .p0_rsp_valid      (p0_rsp_valid),
      .p0_rdata          (p0_rdata),
      .p1_valid          (p1_valid),
      .p1_ready          (p1_ready),
      .p1_we             (p1_we),
      .p1_addr           (p1_addr),
      .p1_wdata          (p1_wdata),
      .p1_rsp_valid      (p1_rsp_valid),
      .p1_rdata          (p1_rdata),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_write         (ram_write),
      .ram_din           (ram_din),
      .ram_dout          (ram_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
      p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
      p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_clear();
`ifdef RAM_CLEAR_EN
      repeat (256) tick();
`endif
   endtask

   localparam logic [15:0] ExpW01 = 16'h1111;
   localparam logic [15:0] ExpW02 = 16'h2222;

   initial begin
      rst_n = 1'b0;
      drv0(1'b1, 1'b1, 8'h33, 16'h1234);
      drv1(1'b1, 1'b0, 8'h44, 16'h0000);
      #2;
      chk("rst_p0_ready", 32'(p0_ready), 32'd0);
      chk("rst_p1_ready", 32'(p1_ready), 32'd0);
      chk("rst_ram_write", 32'(ram_write), 32'd0);
      chk("rst_waddr", 32'(ram_write_address), 32'd0);
      chk("rst_raddr", 32'(ram_read_address), 32'd0);
      chk("rst_din", 32'(ram_din), 32'd0);
      chk("rst_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
      tick(); tick();
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
      drv1(1'b0, 1'b0, 8'h00, 16'h0000);
      rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
      // Clear sequence: P0 read of 0xFF held, not granted for 256 cycles.
      drv0(1'b1, 1'b0, 8'hFF, 16'h0000);
      for (int i = 0; i < 256; i++) begin
         #1;
         chk("clr_p0_ready", 32'(p0_ready), 32'd0);
         chk("clr_write", 32'(ram_write), 32'd1);
         chk("clr_waddr", 32'(ram_write_address), 32'(i));
         chk("clr_din", 32'(ram_din), 32'd0);
         tick();
      end
      #1;
      chk("clr_done_ready", 32'(p0_ready), 32'd1);
      tick();
      chk("clr_rsp_valid", 32'(p0_rsp_valid), 32'd1);
      chk("clr_rdata_ff", 32'(p0_rdata), 32'h0000);
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
`else
      // First cycle after reset: read preloaded word at 0x00.
      drv0(1'b1, 1'b0, 8'h00, 16'h0000);
      #1;
      chk("t6_p0_ready", 32'(p0_ready), 32'd1);
      chk("t6_p1_ready", 32'(p1_ready), 32'd0);
      chk("t6_raddr", 32'(ram_read_address), 32'h00);
      tick();
      chk("t6_rsp_valid", 32'(p0_rsp_valid), 32'd1);
      chk("t6_rdata", 32'(p0_rdata), 32'hA500);
      chk("t6_p1_rsp", 32'(p1_rsp_valid), 32'd0);
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
`endif

      // Write 0x10 then read it back on the next cycle.
      drv0(1'b1, 1'b1, 8'h10, 16'hBEEF);
      #1;
      chk("t1_wr_ready", 32'(p0_ready), 32'd1);
      chk("t1_ram_write", 32'(ram_write), 32'd1);
      chk("t1_waddr", 32'(ram_write_address), 32'h10);
      chk("t1_din", 32'(ram_din), 32'hBEEF);
      tick();
      chk("t1_wr_no_rsp", 32'(p0_rsp_valid), 32'd0);
      drv0(1'b1, 1'b0, 8'h10, 16'h0000);
      #1;
      chk("t1_rd_ready", 32'(p0_ready), 32'd1);
      chk("t1_rd_nowrite", 32'(ram_write), 32'd0);
      chk("t1_raddr", 32'(ram_read_address), 32'h10);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
      chk("t1_rsp_valid", 32'(p0_rsp_valid), 32'd1);
      chk("t1_rdata", 32'(p0_rdata), 32'hBEEF);
      chk("t1_p1_rsp", 32'(p1_rsp_valid), 32'd0);

      // P1 alone for 3 cycles, writing 0x01..0x03; pointer then points at P0.
      for (int i = 1; i <= 3; i++) begin
         drv1(1'b1, 1'b1, 8'(i), 16'(i * 16'h1111));
         #1;
         chk("t3_p1_ready", 32'(p1_ready), 32'd1);
         chk("t3_waddr", 32'(ram_write_address), 32'(i));
         tick();
      end
      drv1(1'b0, 1'b0, 8'h00, 16'h0000);

      // Contention for 4 cycles: grants alternate starting with P0.
      drv0(1'b1, 1'b0, 8'h01, 16'h0000);
      drv1(1'b1, 1'b0, 8'h02, 16'h0000);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("t2_p0_ready", 32'(p0_ready), 32'((c % 2) == 0));
         chk("t2_p1_ready", 32'(p1_ready), 32'((c % 2) == 1));
         chk("t2_raddr", 32'(ram_read_address), ((c % 2) == 0) ? 32'h01 : 32'h02);
         tick();
         chk("t2_p0_rsp", 32'(p0_rsp_valid), 32'((c % 2) == 0));
         chk("t2_p1_rsp", 32'(p1_rsp_valid), 32'((c % 2) == 1));
         chk("t2_rdata", 32'(((c % 2) == 0) ? p0_rdata : p1_rdata),
             32'(((c % 2) == 0) ? ExpW01 : ExpW02));
      end
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
      drv1(1'b0, 1'b0, 8'h00, 16'h0000);
      #1;
      chk("idle_nowrite", 32'(ram_write), 32'd0);
      tick();
      chk("idle_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);

      // P1 read granted, reset next cycle drops the response and resets the pointer.
      drv1(1'b1, 1'b0, 8'h20, 16'h0000);
      #1;
      chk("t4_p1_ready", 32'(p1_ready), 32'd1);
      tick();
      drv0(1'b1, 1'b0, 8'h01, 16'h0000);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
      chk("t4_rst_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
      chk("t4_rst_write", 32'(ram_write), 32'd0);
      tick();
      rst_n = 1'b1;
      wait_clear();
      #1;
      chk("t4_post_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
      chk("t4_ptr_p0", {30'd0, p1_ready, p0_ready}, 32'b01);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 16'h0000);
      drv1(1'b0, 1'b0, 8'h00, 16'h0000);
      chk("t4_p0_rsp", 32'(p0_rsp_valid), 32'd1);
      chk("t4_p1_rsp", 32'(p1_rsp_valid), 32'd0);
`ifdef RAM_CLEAR_EN
      chk("t4_rdata", 32'(p0_rdata), 32'h0000);
`else
      chk("t4_rdata", 32'(p0_rdata), 32'(ExpW01));
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
